// File: rtl/riscv_pkg.sv
// Shared integer-register-file types and constants for decode, hazard and RF units.
package riscv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = $clog2(NREGS);
    localparam int unsigned CNTW  = AW + 1;

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xlen_t;
    typedef logic [CNTW-1:0] busy_cnt_t;

    localparam reg_addr_t REG_ZERO = '0;

    // Scoreboard update request: one strobe plus the register it targets.
    typedef struct packed {
        logic      en;
        reg_addr_t addr;
    } sb_req_t;

endpackage : riscv_pkg

// File: rtl/reg_file_sb_if.sv
// Register-file access bus: read ports, write port, issue strobe and busy status.
interface reg_file_sb_if
    import riscv_pkg::*;
#(
    parameter int unsigned NRD = 2
);

    logic [NRD*AW-1:0]   RA;
    logic [NRD*XLEN-1:0] RD;
    logic [NRD-1:0]      RBUSY;
    logic                WE3;
    reg_addr_t           A3;
    xlen_t               WD3;
    logic                ISS;
    reg_addr_t           ISS_RD;
    busy_cnt_t           BUSY_CNT;

    modport master (
        output RA, WE3, A3, WD3, ISS, ISS_RD,
        input  RD, RBUSY, BUSY_CNT
    );

    modport slave (
        input  RA, WE3, A3, WD3, ISS, ISS_RD,
        output RD, RBUSY, BUSY_CNT
    );

endinterface : reg_file_sb_if

// File: rtl/rf_scoreboard.sv
// Per-register busy bits with a running busy count; issue sets, writeback clears.
module rf_scoreboard
    import riscv_pkg::*;
#(
    parameter int unsigned NRD = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  sb_req_t           set_req,
    input  sb_req_t           clr_req,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rbusy,
    output busy_cnt_t         busy_cnt
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    busy_cnt_t        cnt_q;
    busy_cnt_t        cnt_d;
    logic             set_fire;
    logic             clr_fire;

    // Next busy state: a same-register issue overrides the clear (new producer pending).
    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        set_fire = set_req.en && (set_req.addr != REG_ZERO);
        clr_fire = clr_req.en && (clr_req.addr != REG_ZERO);

        if (clr_fire && busy_q[clr_req.addr] &&
            !(set_fire && (set_req.addr == clr_req.addr))) begin
            busy_d[clr_req.addr] = 1'b0;
            cnt_d                = cnt_d - CNTW'(1);
        end

        if (set_fire && !busy_q[set_req.addr]) begin
            busy_d[set_req.addr] = 1'b1;
            cnt_d                = cnt_d + CNTW'(1);
        end

        busy_d[0] = 1'b0;
    end

    // Busy bits and count share one edge; reset drops all pending state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Per-port lookup of registered busy state (not bypassed by same-cycle writeback).
    always_comb begin
        rbusy = '0;
        for (int k = 0; k < NRD; k++) begin
            rbusy[k] = busy_q[rd_addr[k*AW +: AW]];
        end
    end

    assign busy_cnt = cnt_q;

endmodule : rf_scoreboard

// File: rtl/reg_file_sb.sv
// Integer register file: NRD combinational read ports, one write port, x0 hardwired,
// optional write-to-read bypass, and a busy scoreboard for RAW hazard stalls.
module reg_file_sb
    import riscv_pkg::*;
#(
    parameter int unsigned NRD    = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    reg_file_sb_if.slave bus
);

    xlen_t               regs_q [NREGS];
    xlen_t               regs_d [NREGS];
    logic [NRD*XLEN-1:0] rd_c;
    sb_req_t             set_req;
    sb_req_t             clr_req;

    // Storage next state: writes to x0 are dropped.
    always_comb begin
        regs_d = regs_q;
        if (bus.WE3 && (bus.A3 != REG_ZERO)) begin
            regs_d[bus.A3] = bus.WD3;
        end
    end

    // Storage array; reset clears every entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes: x0 reads zero, optional bypass of the in-flight write.
    always_comb begin
        reg_addr_t ra_k;
        ra_k = REG_ZERO;
        rd_c = '0;
        for (int k = 0; k < NRD; k++) begin
            ra_k = bus.RA[k*AW +: AW];
            if (ra_k == REG_ZERO) begin
                rd_c[k*XLEN +: XLEN] = '0;
            end else if (BYPASS && bus.WE3 && (bus.A3 == ra_k)) begin
                rd_c[k*XLEN +: XLEN] = bus.WD3;
            end else begin
                rd_c[k*XLEN +: XLEN] = regs_q[ra_k];
            end
        end
    end

    assign bus.RD = rd_c;

    // Issue marks the destination busy; writeback releases it.
    always_comb begin
        set_req      = '0;
        clr_req      = '0;
        set_req.en   = bus.ISS;
        set_req.addr = bus.ISS_RD;
        clr_req.en   = bus.WE3;
        clr_req.addr = bus.A3;
    end

    rf_scoreboard #(
        .NRD (NRD)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_req  (set_req),
        .clr_req  (clr_req),
        .rd_addr  (bus.RA),
        .rbusy    (bus.RBUSY),
        .busy_cnt (bus.BUSY_CNT)
    );

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a bypassing and a non-bypassing instance share stimulus,
// both checked every cycle against an array model plus hand-computed literals.
module tb_reg_file_sb;

    localparam int unsigned NRD = 2;
    localparam int unsigned AWB = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  ra;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic        iss;
    logic [4:0]  iss_rd;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [31:0] m_reg  [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    reg_file_sb_if #(.NRD(NRD)) bus_bp ();
    reg_file_sb_if #(.NRD(NRD)) bus_nb ();

    assign bus_bp.RA = ra;     assign bus_nb.RA = ra;
    assign bus_bp.WE3 = we;    assign bus_nb.WE3 = we;
    assign bus_bp.A3 = a3;     assign bus_nb.A3 = a3;
    assign bus_bp.WD3 = wd;    assign bus_nb.WD3 = wd;
    assign bus_bp.ISS = iss;   assign bus_nb.ISS = iss;
    assign bus_bp.ISS_RD = iss_rd; assign bus_nb.ISS_RD = iss_rd;

    reg_file_sb #(.NRD(NRD), .BYPASS(1'b1)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_bp)
    );

    reg_file_sb #(.NRD(NRD), .BYPASS(1'b0)) u_dut_nb (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_nb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural effect of one clock edge.
    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we && a3 != 0) begin
                m_reg[a3]  = wd;
                m_busy[a3] = 1'b0;
            end
            if (iss && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && we && a3 == a) return wd;
        return m_reg[a];
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NRD; k++) begin
                logic [4:0] a;
                a = ra[k*AWB +: AWB];
                check($sformatf("rd_bp%0d", k), bus_bp.RD[k*32 +: 32], m_read(a, 1'b1));
                check($sformatf("rd_nb%0d", k), bus_nb.RD[k*32 +: 32], m_read(a, 1'b0));
                check($sformatf("rbusy_bp%0d", k), 32'(bus_bp.RBUSY[k]), 32'(m_busy[a]));
                check($sformatf("rbusy_nb%0d", k), 32'(bus_nb.RBUSY[k]), 32'(m_busy[a]));
            end
            check("cnt_bp", 32'(bus_bp.BUSY_CNT), 32'(m_count()));
            check("cnt_nb", 32'(bus_nb.BUSY_CNT), 32'(m_count()));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        we = 1'b0; a3 = '0; wd = '0; iss = 1'b0; iss_rd = '0;
    endtask

    task automatic set_ra(input logic [4:0] r0, input logic [4:0] r1);
        ra = {r1, r0};
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = '0;
            m_busy[i] = 1'b0;
        end
        rst_n = 1'b0;
        idle();
        set_ra(5'd0, 5'd0);
        tick();
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        #2;
        check("lit_reset_cnt", 32'(bus_bp.BUSY_CNT), 32'd0);
        check("lit_reset_rd0", bus_bp.RD[31:0], 32'd0);

        // Write x5, issue x9, then reset with a write/issue in the same cycle.
        we = 1'b1; a3 = 5'd5; wd = 32'hDEADBEEF; iss = 1'b1; iss_rd = 5'd9;
        tick();
        idle(); set_ra(5'd5, 5'd9);
        #2;
        check("lit_x5", bus_bp.RD[31:0], 32'hDEADBEEF);
        check("lit_cnt1", 32'(bus_bp.BUSY_CNT), 32'd1);
        rst_n = 1'b0;
        we = 1'b1; a3 = 5'd5; wd = 32'h11111111; iss = 1'b1; iss_rd = 5'd12;
        tick();
        rst_n = 1'b1; idle(); set_ra(5'd5, 5'd9);
        #2;
        check("lit_rst_x5", bus_bp.RD[31:0], 32'd0);
        check("lit_rst_busy", 32'(bus_bp.RBUSY), 32'd0);
        check("lit_rst_cnt", 32'(bus_bp.BUSY_CNT), 32'd0);

        // Register zero ignores writes and issues.
        we = 1'b1; a3 = 5'd0; wd = 32'h12345678; iss = 1'b1; iss_rd = 5'd0; set_ra(5'd0, 5'd0);
        #2;
        check("lit_x0_byp", bus_bp.RD[31:0], 32'd0);
        tick();
        idle();
        #2;
        check("lit_x0_rd", bus_bp.RD[31:0], 32'd0);
        check("lit_x0_cnt", 32'(bus_bp.BUSY_CNT), 32'd0);

        // Bypass versus stored value.
        we = 1'b1; a3 = 5'd7; wd = 32'h0BADF00D;
        tick();
        we = 1'b1; a3 = 5'd7; wd = 32'hA5A5A5A5; set_ra(5'd7, 5'd0);
        #2;
        check("lit_byp_on", bus_bp.RD[31:0], 32'hA5A5A5A5);
        check("lit_byp_off", bus_nb.RD[31:0], 32'h0BADF00D);
        tick();
        idle();
        #2;
        check("lit_byp_off_next", bus_nb.RD[31:0], 32'hA5A5A5A5);

        // Basic issue/writeback of x3.
        iss = 1'b1; iss_rd = 5'd3;
        tick();
        idle(); set_ra(5'd3, 5'd0);
        #2;
        check("lit_x3_busy", 32'(bus_bp.RBUSY[0]), 32'd1);
        check("lit_x3_cnt", 32'(bus_bp.BUSY_CNT), 32'd1);
        we = 1'b1; a3 = 5'd3; wd = 32'h55;
        #2;
        check("lit_x3_busy_nobyp", 32'(bus_bp.RBUSY[0]), 32'd1);
        tick();
        idle();
        #2;
        check("lit_x3_clr", 32'(bus_bp.RBUSY[0]), 32'd0);
        check("lit_x3_cnt0", 32'(bus_bp.BUSY_CNT), 32'd0);
        check("lit_x3_rd", bus_nb.RD[31:0], 32'h55);

        // Collisions.
        we = 1'b1; a3 = 5'd4; wd = 32'h44; iss = 1'b1; iss_rd = 5'd4;
        tick();
        idle(); set_ra(5'd4, 5'd6);
        #2;
        check("lit_x4_busy", 32'(bus_bp.RBUSY), 32'b01);
        check("lit_x4_rd", bus_bp.RD[31:0], 32'h44);
        check("lit_x4_cnt", 32'(bus_bp.BUSY_CNT), 32'd1);
        we = 1'b1; a3 = 5'd4; wd = 32'h66; iss = 1'b1; iss_rd = 5'd6;
        tick();
        idle();
        #2;
        check("lit_x46_busy", 32'(bus_bp.RBUSY), 32'b10);
        check("lit_x46_cnt", 32'(bus_bp.BUSY_CNT), 32'd1);
        check("lit_x4_rd2", bus_bp.RD[31:0], 32'h66);

        // Fill every register, then re-issue one that is already busy.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 1; i < 32; i++) begin
            iss = 1'b1; iss_rd = 5'(i); set_ra(5'(i), 5'(32 - i));
            tick();
        end
        iss = 1'b1; iss_rd = 5'd5;
        tick();
        idle();
        #2;
        check("lit_fill_cnt", 32'(bus_bp.BUSY_CNT), 32'd31);

        // Random traffic with occasional reset.
        for (int n = 0; n < 1000; n++) begin
            rst_n  = ($urandom_range(63) != 0);
            we     = $urandom_range(1) == 1;
            a3     = 5'($urandom_range(31));
            wd     = $urandom;
            iss    = $urandom_range(2) != 0;
            iss_rd = 5'($urandom_range(31));
            if ($urandom_range(3) == 0) set_ra(a3, 5'($urandom_range(31)));
            else set_ra(5'($urandom_range(31)), 5'($urandom_range(31)));
            tick();
        end
        rst_n = 1'b1;
        idle();
        tick();
        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file_sb

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised integer register file with a per-register busy scoreboard, for the next-generation RISC-V core. It provides NRD combinational read ports and one write port. Register 0 is hardwired to zero, and write-to-read bypass is selectable. The scoreboard marks a destination busy at issue and clears it at writeback, which lets the decode stage stall on RAW hazards once the core is pipelined.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=2)
AW, $clog2(NREGS), register address width (derived, not overridden)
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = a read of the register being written this cycle returns WD3; 0 = returns the stored value

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
RA  in  NRD*AW  read addresses; port k uses RA[k*AW +: AW]
RD  out  NRD*XLEN  read data; port k uses RD[k*XLEN +: XLEN]
RBUSY  out  NRD  busy flag of the register addressed by each read port
WE3  in  1  write enable
A3  in  AW  write address
WD3  in  XLEN  write data
ISS  in  1  issue strobe: mark register ISS_RD busy
ISS_RD  in  AW  destination register being issued
BUSY_CNT  out  AW+1  number of registers currently busy

Behaviour:
- Reset: on the rising clk edge with reset=0, every register and every busy bit clears to 0.
  - WE3 and ISS are ignored in that cycle.
  - After reset: RD=0, RBUSY=0, BUSY_CNT=0.
  - Reset asserted mid-operation discards all pending busy state, with no partial update.
- Write: on the rising edge with reset=1, WE3=1 and A3!=0, reg[A3] <= WD3. Writes to register 0 are dropped.
- Read: fully combinational, zero latency.
  - RD[k] = 0 when RA[k]=0.
  - With BYPASS=1, RD[k] = WD3 when WE3 && A3==RA[k] && A3!=0.
  - Otherwise RD[k] = reg[RA[k]].
- Scoreboard: one busy bit per register; bit 0 is constant 0.
  - Issue: ISS=1 && ISS_RD!=0 sets busy[ISS_RD] at the next edge.
  - Writeback: WE3=1 && A3!=0 clears busy[A3] at the next edge.
  - Same-cycle issue and writeback to the same register: busy stays 1, because issue wins and a new producer is pending. Data is still written.
  - Same cycle, different registers: both take effect.
  - Issue to an already-busy register: no change. WAW ordering is the issuer's responsibility.
  - Writeback to a non-busy register: plain write, no error.
- RBUSY[k] = busy[RA[k]], combinational from registered state. It is not bypassed: a writeback clearing busy is visible only from the next cycle.
- BUSY_CNT: registered popcount of the busy bits, updated in the same edge as the bits.
  - Per edge: +1 for a set of a non-busy register; -1 for a clear of a busy register that is not re-issued; both in one cycle on different registers give net 0.
  - Range 0..NREGS-1 (register 0 is never busy); no wrap.
- X-safety: no X on RD, RBUSY or BUSY_CNT after reset, for any address values.

Decomposition:
- Shared package riscv_pkg: XLEN, NREGS, the REG_ZERO constant, and a reg_addr_t typedef, shared with decode and hazard units.
- One sub-module, rf_scoreboard: busy bits plus BUSY_CNT, with set/clear inputs and a per-port busy lookup.
- Storage array and read muxes stay in the top module.

Test Plan:
- Reset: write 0xDEADBEEF to x5, assert reset=0 for one cycle, read x5 -> RD=0, RBUSY=0, BUSY_CNT=0. With reset=0 and WE3=1 in the same cycle, the write is ignored.
- Zero register: WE3=1, A3=0, WD3=0x12345678; ISS=1, ISS_RD=0 -> reading x0 gives 0, RBUSY=0, BUSY_CNT unchanged.
- Bypass: BYPASS=1, WE3=1, A3=7, WD3=0xA5A5A5A5 with RA0=7 in the same cycle -> RD0=0xA5A5A5A5 combinationally. With BYPASS=0 -> old value until the next cycle.
- Scoreboard basic:
  - Issue x3 -> next cycle RBUSY=1, BUSY_CNT=1.
  - Writeback x3 with 0x55 -> next cycle RBUSY=0, BUSY_CNT=0, RD=0x55.
- Collisions:
  - Issue x4 and write x4 in the same cycle -> x4 stays busy, data written, BUSY_CNT=1.
  - Issue x6 while writing busy x4 -> BUSY_CNT stays 1 (x6 busy, x4 clear).
- Fill/random: issue x1..x31 -> BUSY_CNT=31, no overflow. Then run 1000 cycles of random issue/write against a reference model, checking RD, RBUSY and BUSY_CNT every cycle.
